// File: rtl/crc_stream_if.sv
// Handshake bundle for crc_stream_engine: input beat channel and result channel.
// Optional compare ports are present only when CRC_ENGINE_CHECK_EN is defined.
interface crc_stream_if #(
  parameter int DATA_W = 128,
  parameter int CRC_W  = 16
);
  localparam int NBYTES = DATA_W / 8;
  localparam int MOD_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic [MOD_W-1:0]  in_mod;
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  out_crc;
  logic              out_proto_err;
`ifdef CRC_ENGINE_CHECK_EN
  logic [CRC_W-1:0]  in_exp_crc;
  logic              out_match;

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_mod, out_ready, in_exp_crc,
    input  in_ready, out_valid, out_crc, out_proto_err, out_match
  );
  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_mod, out_ready, in_exp_crc,
    output in_ready, out_valid, out_crc, out_proto_err, out_match
  );
`else
  modport master (
    output in_valid, in_data, in_sop, in_eop, in_mod, out_ready,
    input  in_ready, out_valid, out_crc, out_proto_err
  );
  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_mod, out_ready,
    output in_ready, out_valid, out_crc, out_proto_err
  );
`endif
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accumulates an MSB-first LFSR CRC across sop/eop framed
// packets (partial final beat allowed) and presents one registered result per
// packet on a valid/ready channel. Framing violations raise a one-cycle pulse.
// Optional macro CRC_ENGINE_CHECK_EN adds an expected-CRC compare (out_match).
module crc_stream_engine #(
  parameter int          DATA_W  = 128,
  parameter int          CRC_W   = 16,
  parameter logic [31:0] POLY    = 32'h0000_8005,
  parameter logic [31:0] INIT    = 32'h0000_0000,
  parameter logic [31:0] XOR_OUT = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  crc_stream_if.slave  bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int MOD_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BCNT_W = $clog2(NBYTES + 1);

  localparam logic [CRC_W-1:0]  POLY_T    = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0]  INIT_T    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0]  XOR_T     = XOR_OUT[CRC_W-1:0];
  localparam logic [MOD_W:0]    NBYTES_M  = (MOD_W + 1)'(NBYTES);
  localparam logic [BCNT_W-1:0] NBYTES_B  = BCNT_W'(NBYTES);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Bit-serial LFSR unrolled over the leading nbytes bytes of the beat (MSB first).
  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0]  crc_in,
    input logic [DATA_W-1:0] data,
    input logic [BCNT_W-1:0] nbytes
  );
    logic [CRC_W-1:0] c;
    logic             fb;
    c  = crc_in;
    fb = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (BCNT_W'(i) < nbytes) begin
        for (int j = 0; j < 8; j++) begin
          fb = c[CRC_W-1] ^ data[DATA_W-1-8*i-j];
          c  = (c << 1) ^ (fb ? POLY_T : {CRC_W{1'b0}});
        end
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  state_t            state_r, state_nxt;
  logic [CRC_W-1:0]  crc_r, crc_nxt;
  logic [CRC_W-1:0]  res_r, res_nxt;
  logic              out_valid_r, valid_nxt;
  logic              err_r, err_nxt;
  logic              accept_s, consume_s;
  logic [MOD_W:0]    mod_wide_s, mod_eff_s;
  logic [BCNT_W-1:0] nbytes_s;
  logic [CRC_W-1:0]  seed_s, step_s, fin_s;
`ifdef CRC_ENGINE_CHECK_EN
  logic              match_r, match_nxt;
`endif

  assign bus.in_ready      = !out_valid_r || bus.out_ready;
  assign accept_s          = bus.in_valid && bus.in_ready;
  assign consume_s         = out_valid_r && bus.out_ready;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_crc       = res_r;
  assign bus.out_proto_err = err_r;
`ifdef CRC_ENGINE_CHECK_EN
  assign bus.out_match     = match_r;
`endif

  // Byte count consumed from this beat: in_mod (mod beat bytes) on eop, else all.
  always_comb begin
    mod_wide_s = {1'b0, bus.in_mod};
    if (mod_wide_s >= NBYTES_M) begin
      mod_eff_s = mod_wide_s - NBYTES_M;
    end else begin
      mod_eff_s = mod_wide_s;
    end
    if (bus.in_eop && (mod_eff_s != '0)) begin
      nbytes_s = BCNT_W'(mod_eff_s);
    end else begin
      nbytes_s = NBYTES_B;
    end
  end

  // A sop beat always restarts from INIT, otherwise continue the running CRC.
  always_comb begin
    if (bus.in_sop) begin
      seed_s = INIT_T;
    end else begin
      seed_s = crc_r;
    end
    step_s = crc_step(seed_s, bus.in_data, nbytes_s);
    fin_s  = step_s ^ XOR_T;
  end

  // Framing FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and datapath update decisions for each accepted beat.
  always_comb begin
    state_nxt = state_r;
    crc_nxt   = crc_r;
    res_nxt   = res_r;
    err_nxt   = 1'b0;
`ifdef CRC_ENGINE_CHECK_EN
    match_nxt = match_r;
`endif
    if (consume_s) begin
      valid_nxt = 1'b0;
    end else begin
      valid_nxt = out_valid_r;
    end
    if (accept_s) begin
      if (bus.in_sop) begin
        // A sop while a packet is open abandons that packet.
        if (state_r == ACTIVE) begin
          err_nxt = 1'b1;
        end else begin
          err_nxt = 1'b0;
        end
        if (bus.in_eop) begin
          res_nxt   = fin_s;
          valid_nxt = 1'b1;
          crc_nxt   = INIT_T;
          state_nxt = IDLE;
`ifdef CRC_ENGINE_CHECK_EN
          match_nxt = (fin_s == bus.in_exp_crc);
`endif
        end else begin
          crc_nxt   = step_s;
          state_nxt = ACTIVE;
        end
      end else begin
        case (state_r)
          ACTIVE: begin
            if (bus.in_eop) begin
              res_nxt   = fin_s;
              valid_nxt = 1'b1;
              crc_nxt   = INIT_T;
              state_nxt = IDLE;
`ifdef CRC_ENGINE_CHECK_EN
              match_nxt = (fin_s == bus.in_exp_crc);
`endif
            end else begin
              crc_nxt = step_s;
            end
          end
          IDLE: begin
            // Continuation beat without an open packet: drop it.
            err_nxt = 1'b1;
          end
          default: begin
            state_nxt = IDLE;
            crc_nxt   = INIT_T;
          end
        endcase
      end
    end else begin
      state_nxt = state_r;
    end
  end

  // Running CRC, result register, valid flag and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_r       <= INIT_T;
      res_r       <= {CRC_W{1'b0}};
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      crc_r       <= crc_nxt;
      res_r       <= res_nxt;
      out_valid_r <= valid_nxt;
      err_r       <= err_nxt;
    end
  end

`ifdef CRC_ENGINE_CHECK_EN
  // Compare flag registered alongside the result it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_r <= 1'b0;
    end else begin
      match_r <= match_nxt;
    end
  end
`endif

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised, handshaked streaming CRC engine for the classifier datapath. It accumulates a CRC of configurable width and polynomial across multi-beat packets delimited by sop/eop. A partial final beat is supported. One registered result per packet is presented on a valid/ready output. It generalises the fixed single-beat CRC-16/128-bit hash stage to arbitrary widths, packet framing and backpressure.

## Interface
Parameters:
- DATA_W, 128: input beat width in bits; multiple of 8, 8..512.
- CRC_W, 16: CRC width in bits, 8..32.
- POLY, 'h8005: generator polynomial with the implicit x^CRC_W term omitted. The default is x^16+x^15+x^2+1.
- INIT, 0: running CRC value loaded at sop.
- XOR_OUT, 0: value XORed onto the final CRC before output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts beat.
- in_data  in  DATA_W  beat data; first serial bit is in_data[DATA_W-1], bytes consumed MSB-first.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- in_mod  in  $clog2(DATA_W/8)  valid bytes on eop beat; 0 means all bytes. Valid bytes are the most-significant ones. Ignored when in_eop=0.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_crc  out  CRC_W  final CRC (XOR_OUT applied).
- out_proto_err  out  1  one-cycle pulse on a framing violation.
- in_exp_crc  in  CRC_W  expected CRC, sampled on the eop beat (CRC_ENGINE_CHECK_EN only).
- out_match  out  1  out_crc == sampled in_exp_crc (CRC_ENGINE_CHECK_EN only).

## Operation
- Beat transfer: the beat transfers when in_valid && in_ready.
- in_ready rule: in_ready = !out_valid || out_ready. The single result register frees in the same cycle it is consumed.
- States are IDLE and ACTIVE. The result register is independent of state.
- IDLE + beat with sop, eop=0: crc ← step(INIT, beat); go to ACTIVE.
- IDLE + beat with sop=1, eop=1: compute step(INIT, partial beat) and write the result register; stay in IDLE.
- IDLE + beat with sop=0: drop the beat; pulse out_proto_err; crc unchanged.
- ACTIVE + beat with sop=0, eop=0: crc ← step(crc, beat).
- ACTIVE + beat with eop=1: result ← step(crc, partial beat) ^ XOR_OUT; out_valid ← 1; go to IDLE.
- ACTIVE + beat with sop=1: the current packet is abandoned (no result); pulse out_proto_err; restart from INIT using this beat, with the same eop handling as IDLE.
- Step function: bitwise MSB-first LFSR. For each consumed bit b: fb = crc[CRC_W-1]^b; crc = (crc<<1) ^ (fb ? POLY : 0). It is unrolled combinationally over all DATA_W bits. Bytes at index >= in_mod, counting from the MSB, are skipped on the eop beat.
- Width rules: POLY, INIT and XOR_OUT are truncated to CRC_W. in_mod is taken modulo DATA_W/8.

## Timing
- The eop beat accepted at cycle N gives out_valid=1 with out_crc stable at N+1, held until out_ready.
- Back-to-back single-beat packets with out_ready=1 sustain one result per cycle.
- Reset values: out_valid=0, out_crc=0, out_proto_err=0, out_match=0, state IDLE, running crc=INIT.
- Reset mid-packet discards the partial CRC and any unconsumed result.
- The out_proto_err pulse is registered and asserts at N+1 for a violating beat accepted at N.

## Configuration
- CRC_ENGINE_CHECK_EN defined: in_exp_crc is sampled on the eop beat, and out_match is registered alongside out_crc with the same valid/hold behaviour.
- CRC_ENGINE_CHECK_EN undefined: the in_exp_crc and out_match ports are absent. No compare logic is built.

## Test plan
- "123456789" check string: DATA_W=128, single beat, sop=eop=1, in_mod=9, ASCII '1'..'9' in bits 127:56, rest 0. Required: out_crc=16'hFEE8 one cycle later.
- Same string split into two beats, "1234" (in_mod ignored) + "56789": 32-bit configuration DATA_W=32 with in_mod=0 then a 64-bit beat. Simpler: use DATA_W=128, beat1 all 16 bytes 0x00, beat2 eop in_mod=9 with the check string. Required: out_crc=16'hFEE8, because leading zero bytes with INIT=0 do not change the CRC.
- Backpressure: hold out_ready=0 while a second packet arrives. Required: in_ready=0 and the first result stays stable. Release out_ready: first result consumed, second beat accepted in the same cycle.
- Framing errors: beat with sop=0 in IDLE gives an out_proto_err pulse and no out_valid. sop mid-packet gives an out_proto_err pulse; the new packet alone yields 16'hFEE8.
- Reset mid-packet: assert rst_n=0 after 2 of 3 beats. Required: all outputs return to 0; a following check-string packet yields 16'hFEE8.
- With CRC_ENGINE_CHECK_EN: in_exp_crc=16'hFEE8 gives out_match=1; in_exp_crc=16'hFEE9 gives out_match=0.
